// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: multi-cycle add/subtract sequencer driving one external 3-bit
// ripple-carry slice. Operands are processed 3 bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register.
// Optional feature macro: SUM_SEQ_OVF_EN (signed overflow flag register).
module sum_seq_ctrl #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       slice_x,
  output logic [2:0]       slice_y,
  output logic             slice_ci,
  input  logic [2:0]       slice_z,
  input  logic             slice_co,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / 3;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r, state_nxt;
  logic [IDXW-1:0]   idx_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;      // raw operand B; inversion for subtract applied at the slice port
  logic              op_r;
  logic              carry_r;
  logic [WIDTH-1:0]  result_r;
  logic              cout_r;
  logic              busy_r;
  logic              done_r;
  logic [2:0]        chunk_x, chunk_y;

  // Next-state logic for the sequencer FSM
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (init) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select the current operand chunk addressed by idx
  always_comb begin
    chunk_x = 3'd0;
    chunk_y = 3'd0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_r == IDXW'(i)) begin
        chunk_x = a_r[3*i +: 3];
        chunk_y = b_r[3*i +: 3] ^ {3{op_r}};
      end else begin
        chunk_x = chunk_x;
        chunk_y = chunk_y;
      end
    end
  end

  // Drive the slice only while running; quiet zeros otherwise
  always_comb begin
    slice_x  = 3'd0;
    slice_y  = 3'd0;
    slice_ci = 1'b0;
    if (state_r == RUN) begin
      slice_x  = chunk_x;
      slice_y  = chunk_y;
      slice_ci = carry_r;
    end else begin
      slice_x  = 3'd0;
      slice_y  = 3'd0;
      slice_ci = 1'b0;
    end
  end

  // State register, operand capture, carry chain and result assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 1'b0;
      carry_r  <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      case (state_r)
        IDLE: begin
          if (init) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op_sub;
            carry_r <= op_sub;   // +1 of two's complement negation enters as carry-in
            idx_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx_r == IDXW'(i)) begin
              result_r[3*i +: 3] <= slice_z;
            end
          end
          carry_r <= slice_co;
          if (idx_r == LAST_IDX) begin
            cout_r <= slice_co;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUM_SEQ_OVF_EN
  logic ovf_r;
  logic msb_cin;

  // Carry into the MSB recovered from the last chunk's top bit
  assign msb_cin = slice_x[2] ^ slice_y[2] ^ slice_z[2];

  // Signed overflow: carry into MSB differs from carry out of MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if ((state_r == RUN) && (idx_r == LAST_IDX)) begin
      ovf_r <= msb_cin ^ slice_co;
    end
  end

  assign overflow = ovf_r;
`else
  assign overflow = 1'b0;
`endif

  assign result = result_r;
  assign cout   = cout_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Scoreboard testbench for sum_seq_ctrl (WIDTH=9) with a behavioural 3-bit
// ripple-carry slice attached to the slice ports.
module tb_sum_seq_ctrl;

  localparam int WIDTH  = 9;
  localparam int NCHUNK = WIDTH / 3;
  localparam int PERIOD = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init = 1'b0;
  logic             op_sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       slice_x, slice_y, slice_z;
  logic             slice_ci, slice_co;
  logic [WIDTH-1:0] result;
  logic             cout, overflow, busy, done;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ovf;
    time              t_issue;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  sum_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .init(init), .op_sub(op_sub), .a(a), .b(b),
    .slice_x(slice_x), .slice_y(slice_y), .slice_ci(slice_ci),
    .slice_z(slice_z), .slice_co(slice_co),
    .result(result), .cout(cout), .overflow(overflow), .busy(busy), .done(done)
  );

  // Behavioural sum3bcc slice
  assign {slice_co, slice_z} = {1'b0, slice_x} + {1'b0, slice_y} + {3'd0, slice_ci};

  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on the operands
  function automatic exp_t model(input int av, input int bv, input bit sub);
    exp_t e;
    int   full;
    bit   sa, sb_, sr;
    full = sub ? (av - bv) : (av + bv);
    e.res = WIDTH'(full & ((1 << WIDTH) - 1));
    e.co  = sub ? (av >= bv) : (full >= (1 << WIDTH));
    sa  = av[WIDTH-1];
    sb_ = bv[WIDTH-1];
    sr  = e.res[WIDTH-1];
`ifdef SUM_SEQ_OVF_EN
    e.ovf = sub ? ((sa != sb_) && (sr != sa)) : ((sa == sb_) && (sr != sa));
`else
    e.ovf = 1'b0;
`endif
    e.t_issue = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no pending op at t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("cout", cout, e.co);
        check("overflow", overflow, e.ovf);
        check("busy_at_done", busy, 0);
        check("latency", $time - e.t_issue, NCHUNK*PERIOD + PERIOD/2);
      end
    end
  end

  task automatic do_op(input int av, input int bv, input bit sub);
    exp_t e;
    @(posedge clk); #1;
    a = WIDTH'(av); b = WIDTH'(bv); op_sub = sub; init = 1'b1;
    @(posedge clk);
    e = model(av, bv, sub);
    e.t_issue = $time;
    sb.push_back(e);
    #1;
    init = 1'b0;
    a = WIDTH'($urandom);   // late operand changes must be ignored
    b = WIDTH'($urandom);
    op_sub = $urandom_range(0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("done_timeout_pending", sb.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_slice_x", slice_x, 0);
    rst = 1'b1;

    // Directed cases
    do_op(200, 100, 1'b0); wait_idle();
    do_op(511, 1, 1'b0);   wait_idle();
    do_op(5, 7, 1'b1);     wait_idle();
    do_op(7, 5, 1'b1);     wait_idle();

    // init re-pulse during RUN is ignored
    do_op(200, 100, 1'b0);
    @(posedge clk); #1;
    a = 9'd1; b = 9'd1; op_sub = 1'b0; init = 1'b1;
    check("busy_in_run", busy, 1);
    @(posedge clk); #1;
    init = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);

    // Reset one cycle after init aborts the operation
    do_op(100, 50, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    check("abort_slice_y", slice_y, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    do_op(3, 4, 1'b0); wait_idle();

    // Boundary operands
    do_op(0, 0, 1'b1);     wait_idle();
    do_op(255, 1, 1'b0);   wait_idle();
    do_op(256, 1, 1'b1);   wait_idle();
    do_op(511, 511, 1'b0); wait_idle();

    // Randomized operations
    for (int k = 0; k < 30; k++) begin
      do_op($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1));
      wait_idle();
    end

    repeat (4) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
